// File: rtl/memory_arbiter.sv
// Arbitrates the single main-memory port between the I-cache and the D-cache.
// A grant is held until completion or abort, and is always followed by a one-cycle strobe gap.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no grant; picks a requester, round-robin on a tie
// BUSY_INST  | I-cache read in flight on the memory port
// BUSY_DATA  | D-cache read or write in flight on the memory port
// RELEASE    | strobes held low for one cycle before returning to IDLE
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] instAddress,
  input  logic                  instReadEnable,
  output logic [DATA_WIDTH-1:0] instDataOut,
  output logic                  instReady,
  input  logic [ADDR_WIDTH-1:0] dataAddress,
  input  logic                  dataReadEnable,
  input  logic                  dataWriteEnable,
  input  logic [DATA_WIDTH-1:0] dataDataIn,
  output logic [DATA_WIDTH-1:0] dataDataOut,
  output logic                  dataReady,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic [DATA_WIDTH-1:0] memoryDataOut,
  input  logic [DATA_WIDTH-1:0] memoryDataIn,
  output logic                  memoryReadEnable,
  output logic                  memoryWriteEnable,
  input  logic                  memoryReady,
  output logic                  timeoutError
);

  typedef enum logic [1:0] {IDLE, BUSY_INST, BUSY_DATA, RELEASE} state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_ENABLED = (TIMEOUT_CYCLES != 0);

  state_t          state;
  logic            lastGrantData;
  logic [WD_W-1:0] wdCount;
  logic            instReq;
  logic            dataReq;
  logic            wdExpire;
  logic            abortNow;
  logic            done;

  assign instReq = instReadEnable;
  assign dataReq = dataReadEnable | dataWriteEnable;

  // Watchdog is a down-counter loaded at grant; terminal count lands on the last allowed BUSY cycle.
  assign wdExpire = WD_ENABLED && (wdCount == '0) && !memoryReady;

  always_comb begin
    abortNow = 1'b0;
    case (state)
      BUSY_INST: abortNow = !instReq || (instAddress != memoryAddress) || wdExpire;
      BUSY_DATA: abortNow = !dataReq || (dataAddress != memoryAddress) || wdExpire;
      default:   abortNow = 1'b0;
    endcase
  end

  // Reset masks the pulse so a transaction cut short by reset never reports completion.
  assign done        = memoryReady && !abortNow && !reset;
  assign instReady   = (state == BUSY_INST) && done;
  assign dataReady   = (state == BUSY_DATA) && done;
  assign instDataOut = memoryDataIn;
  assign dataDataOut = memoryDataIn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      lastGrantData     <= 1'b0;
      wdCount           <= '0;
      memoryAddress     <= '0;
      memoryDataOut     <= '0;
      memoryReadEnable  <= 1'b0;
      memoryWriteEnable <= 1'b0;
      timeoutError      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dataReq && (!instReq || !lastGrantData)) begin
            state             <= BUSY_DATA;
            lastGrantData     <= 1'b1;
            wdCount           <= WD_LOAD;
            memoryAddress     <= dataAddress;
            memoryDataOut     <= dataDataIn;
            memoryReadEnable  <= dataReadEnable;
            memoryWriteEnable <= !dataReadEnable;
          end else if (instReq) begin
            state             <= BUSY_INST;
            lastGrantData     <= 1'b0;
            wdCount           <= WD_LOAD;
            memoryAddress     <= instAddress;
            memoryDataOut     <= '0;
            memoryReadEnable  <= 1'b1;
            memoryWriteEnable <= 1'b0;
          end
        end
        BUSY_INST, BUSY_DATA: begin
          if (abortNow || memoryReady) begin
            state             <= RELEASE;
            memoryReadEnable  <= 1'b0;
            memoryWriteEnable <= 1'b0;
            if (wdExpire) timeoutError <= 1'b1;
          end else if (wdCount != '0) begin
            wdCount <= wdCount - WD_W'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a 4-cycle watchdog; expected values are hand-derived.
module tb_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] instAddress;
  logic          instReadEnable;
  logic [DW-1:0] instDataOut;
  logic          instReady;
  logic [AW-1:0] dataAddress;
  logic          dataReadEnable;
  logic          dataWriteEnable;
  logic [DW-1:0] dataDataIn;
  logic [DW-1:0] dataDataOut;
  logic          dataReady;
  logic [AW-1:0] memoryAddress;
  logic [DW-1:0] memoryDataOut;
  logic [DW-1:0] memoryDataIn;
  logic          memoryReadEnable;
  logic          memoryWriteEnable;
  logic          memoryReady;
  logic          timeoutError;

  int total = 0;
  int bad   = 0;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .instAddress(instAddress), .instReadEnable(instReadEnable),
    .instDataOut(instDataOut), .instReady(instReady),
    .dataAddress(dataAddress), .dataReadEnable(dataReadEnable),
    .dataWriteEnable(dataWriteEnable), .dataDataIn(dataDataIn),
    .dataDataOut(dataDataOut), .dataReady(dataReady),
    .memoryAddress(memoryAddress), .memoryDataOut(memoryDataOut),
    .memoryDataIn(memoryDataIn), .memoryReadEnable(memoryReadEnable),
    .memoryWriteEnable(memoryWriteEnable), .memoryReady(memoryReady),
    .timeoutError(timeoutError)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow a further 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clearInputs();
    instAddress     = '0;
    instReadEnable  = 1'b0;
    dataAddress     = '0;
    dataReadEnable  = 1'b0;
    dataWriteEnable = 1'b0;
    dataDataIn      = '0;
    memoryDataIn    = '0;
    memoryReady     = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1;
    clearInputs();
    step();
    step();
    settle();
    checkVal("rst_rd_en",   memoryReadEnable,  0);
    checkVal("rst_wr_en",   memoryWriteEnable, 0);
    checkVal("rst_addr",    memoryAddress,     0);
    checkVal("rst_wdata",   memoryDataOut,     0);
    checkVal("rst_i_rdy",   instReady,         0);
    checkVal("rst_d_rdy",   dataReady,         0);
    checkVal("rst_timeout", timeoutError,      0);
    reset = 1'b0;

    // Instruction read, memoryReady two cycles after the strobe
    instAddress    = 32'h100;
    instReadEnable = 1'b1;
    memoryDataIn   = 32'h1122_3344;
    settle();
    checkVal("t1_idle_no_strobe", memoryReadEnable, 0);
    step(); settle();
    checkVal("t1_rd_en",  memoryReadEnable,  1);
    checkVal("t1_wr_en",  memoryWriteEnable, 0);
    checkVal("t1_addr",   memoryAddress,     32'h100);
    checkVal("t1_rdy_c0", instReady,         0);
    step(); settle();
    checkVal("t1_rdy_c1", instReady,         0);
    step();
    memoryReady = 1'b1;
    settle();
    checkVal("t1_rdy_c2", instReady,   1);
    checkVal("t1_rdata",  instDataOut, 32'h1122_3344);
    checkVal("t1_d_rdy",  dataReady,   0);
    step();
    memoryReady    = 1'b0;
    instReadEnable = 1'b0;
    settle();
    checkVal("t1_rel_rd", memoryReadEnable, 0);
    checkVal("t1_rel_rdy", instReady,       0);
    step(); settle();
    checkVal("t1_idle_rd", memoryReadEnable, 0);

    // Tie from reset goes to DATA, then strict alternation with memory always ready
    doReset();
    instAddress    = 32'h200;
    instReadEnable = 1'b1;
    dataAddress    = 32'h300;
    dataReadEnable = 1'b1;
    memoryReady    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); settle();
      checkVal($sformatf("t2_addr%0d", k), memoryAddress, (k % 2 == 0) ? 32'h300 : 32'h200);
      checkVal($sformatf("t2_drdy%0d", k), dataReady, (k % 2 == 0) ? 1 : 0);
      checkVal($sformatf("t2_irdy%0d", k), instReady, (k % 2 == 0) ? 0 : 1);
      step();
      step();
    end

    // Data write
    doReset();
    dataAddress     = 32'h8000_0040;
    dataDataIn      = 32'hDEAD_BEEF;
    dataWriteEnable = 1'b1;
    step(); settle();
    checkVal("t3_wr_en", memoryWriteEnable, 1);
    checkVal("t3_rd_en", memoryReadEnable,  0);
    checkVal("t3_addr",  memoryAddress,     32'h8000_0040);
    checkVal("t3_wdata", memoryDataOut,     32'hDEAD_BEEF);
    checkVal("t3_rdy_early", dataReady,     0);
    memoryReady = 1'b1;
    settle();
    checkVal("t3_rdy", dataReady, 1);
    step();
    memoryReady     = 1'b0;
    dataWriteEnable = 1'b0;
    settle();
    checkVal("t3_rel_wr", memoryWriteEnable, 0);

    // Both data enables high: treated as a read
    doReset();
    dataAddress     = 32'h44;
    dataReadEnable  = 1'b1;
    dataWriteEnable = 1'b1;
    step(); settle();
    checkVal("t3b_rd_en", memoryReadEnable,  1);
    checkVal("t3b_wr_en", memoryWriteEnable, 0);
    // Requester withdraws mid-flight: abort beats memoryReady
    dataReadEnable  = 1'b0;
    dataWriteEnable = 1'b0;
    memoryReady     = 1'b1;
    settle();
    checkVal("t3b_drop_rdy", dataReady, 0);
    step(); settle();
    checkVal("t3b_rel_rd", memoryReadEnable, 0);

    // Address change mid-BUSY aborts, then re-grant with the new address
    doReset();
    instAddress    = 32'h400;
    instReadEnable = 1'b1;
    step(); settle();
    checkVal("t4_addr_a", memoryAddress, 32'h400);
    instAddress = 32'h404;
    memoryReady = 1'b1;
    settle();
    checkVal("t4_abort_rdy", instReady, 0);
    step();
    memoryReady = 1'b0;
    settle();
    checkVal("t4_rel_rd", memoryReadEnable, 0);
    step(); settle();
    checkVal("t4_idle_rd", memoryReadEnable, 0);
    step(); settle();
    checkVal("t4_regrant_rd", memoryReadEnable, 1);
    checkVal("t4_addr_b",     memoryAddress,    32'h404);
    memoryReady = 1'b1;
    settle();
    checkVal("t4_rdy", instReady, 1);

    // Watchdog: 4 BUSY cycles without memoryReady
    doReset();
    instAddress    = 32'h500;
    instReadEnable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step(); settle();
      checkVal($sformatf("t5_strobe_c%0d", c), memoryReadEnable, 1);
      checkVal($sformatf("t5_err_c%0d", c),    timeoutError,     0);
      checkVal($sformatf("t5_rdy_c%0d", c),    instReady,        0);
    end
    step(); settle();
    checkVal("t5_rel_rd",  memoryReadEnable, 0);
    checkVal("t5_err_set", timeoutError,     1);
    instReadEnable = 1'b0;
    step(); step(); settle();
    checkVal("t5_err_sticky", timeoutError, 1);
    doReset();
    settle();
    checkVal("t5_err_clr", timeoutError, 0);

    // Reset during BUSY_DATA with memoryReady high
    dataAddress    = 32'h600;
    dataReadEnable = 1'b1;
    step(); settle();
    checkVal("t6_busy_rd", memoryReadEnable, 1);
    reset       = 1'b1;
    memoryReady = 1'b1;
    settle();
    checkVal("t6_rst_rdy", dataReady, 0);
    step(); settle();
    checkVal("t6_rd_en", memoryReadEnable,  0);
    checkVal("t6_wr_en", memoryWriteEnable, 0);
    checkVal("t6_addr",  memoryAddress,     0);
    checkVal("t6_wdata", memoryDataOut,     0);
    checkVal("t6_drdy",  dataReady,         0);
    checkVal("t6_err",   timeoutError,      0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
